// File: rtl/alu_b_operand_stage.sv
// ALU port-B operand stage: selects the B operand from register B, data
// memory, the literal field, zero or the forwarded result, and presents it
// through a valid/ready output register. Memory reads use a request/ack
// sub-handshake with a timeout and a one-entry hold buffer.
module alu_b_operand_stage #(
  parameter int WIDTH       = 8,
  parameter int LIT_W       = 8,
  parameter int SIGN_EXT    = 0,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       sel,
  input  logic [WIDTH-1:0] reg_b,
  input  logic [LIT_W-1:0] lit,
  input  logic [WIDTH-1:0] fwd_data,
  output logic             mem_req,
  input  logic             mem_ack,
  input  logic [WIDTH-1:0] mem_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_b,
  output logic             out_err,
  output logic             err_sticky
);

  localparam int CNT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MEM_WAIT = 2'd1,
    HOLD     = 2'd2
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] hold_data;
  logic             hold_err;

  logic             slot_free;
  logic             accept;
  logic             mem_done;
  logic [WIDTH-1:0] mem_res_data;
  logic             mem_res_err;
  logic [WIDTH-1:0] lit_ext;
  logic             lit_fill;
  logic [WIDTH-1:0] sel_data;
  logic             sel_err;
  logic             load;
  logic [WIDTH-1:0] load_data;
  logic             load_err;

  assign slot_free = !out_valid || out_ready;
  // in_ready is forced low while reset is asserted, not just after the edge.
  assign in_ready  = rst_n && (state == IDLE) && slot_free;
  assign accept    = in_valid && in_ready;
  assign mem_req   = (state == MEM_WAIT);

  // A timeout is handled exactly like an ack that returned zero with an error.
  assign mem_done     = (state == MEM_WAIT) && (mem_ack || (cnt == CNT_LAST));
  assign mem_res_data = mem_ack ? mem_data : '0;
  assign mem_res_err  = !mem_ack;

  // Literal extension: low LIT_W bits copied, upper bits sign or zero fill.
  assign lit_fill = (SIGN_EXT != 0) ? lit[LIT_W-1] : 1'b0;
  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_lit
      if (gi < LIT_W) begin : g_low
        assign lit_ext[gi] = lit[gi];
      end else begin : g_high
        assign lit_ext[gi] = lit_fill;
      end
    end
  endgenerate

  // Operand for the non-memory sources; illegal codes yield zero with error.
  always_comb begin
    sel_data = '0;
    sel_err  = 1'b0;
    case (sel)
      3'b000:  sel_data = reg_b;
      3'b001:  sel_data = '0;
      3'b010:  sel_data = lit_ext;
      3'b011:  sel_data = '0;
      3'b100:  sel_data = fwd_data;
      default: sel_err  = 1'b1;
    endcase
  end

  // Decide whether, and from where, the output register loads this cycle.
  always_comb begin
    load      = 1'b0;
    load_data = '0;
    load_err  = 1'b0;
    case (state)
      IDLE: begin
        if (accept && (sel != 3'b001)) begin
          load      = 1'b1;
          load_data = sel_data;
          load_err  = sel_err;
        end
      end
      MEM_WAIT: begin
        if (mem_done && slot_free) begin
          load      = 1'b1;
          load_data = mem_res_data;
          load_err  = mem_res_err;
        end
      end
      HOLD: begin
        if (slot_free) begin
          load      = 1'b1;
          load_data = hold_data;
          load_err  = hold_err;
        end
      end
      default: begin
        load = 1'b0;
      end
    endcase
  end

  // Sequencer, timeout counter, hold buffer and output register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      hold_data  <= '0;
      hold_err   <= 1'b0;
      out_valid  <= 1'b0;
      out_b      <= '0;
      out_err    <= 1'b0;
      err_sticky <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept && (sel == 3'b001)) begin
            state <= MEM_WAIT;
            cnt   <= '0;
          end
        end
        MEM_WAIT: begin
          if (mem_done) begin
            cnt <= '0;
            if (slot_free) begin
              state <= IDLE;
            end else begin
              // Slot still occupied: park the result until the ALU drains it.
              hold_data <= mem_res_data;
              hold_err  <= mem_res_err;
              state     <= HOLD;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        HOLD: begin
          if (slot_free) begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase

      if (load) begin
        out_valid <= 1'b1;
        out_b     <= load_data;
        out_err   <= load_err;
        if (load_err) begin
          err_sticky <= 1'b1;
        end
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
